reg_file_2r1w: RTL

- 32-entry x 32-bit general-purpose register file with two read ports and one write port.
- Sits directly downstream of the 8:1 writeback select mux (MUX8T1). That mux's DOUT drives WD, and the register file's read ports feed the operand stage.
- Register x0 is hardwired to zero.
- Writes are synchronous. Reads are combinational. All storage clears on reset.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/reg_file_2r1w.sv | 81 ++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types for writeback mux, register file and decode stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

  // True when the address names the hardwired-zero register x0.
  function automatic logic is_reg_zero(input reg_addr_t a);
    return (a == REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 2-read / 1-write register file, x0 hardwired to zero, async active-low clear.
// Latency: writes commit on rising CLK; reads are combinational (0 cycles).
//   With REGFILE_BYPASS_EN defined, a same-cycle write is forwarded to matching read ports.
// Backpressure: none; a write is accepted every cycle WE=1.
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int NPORT = 2;

  // Only x1..x(NREG-1) have storage; x0 is synthesised as a constant.
  logic [DATA_W-1:0] store [1:NREG-1];
  // Full-range read view with x0 tied to zero, so read muxes index 0..NREG-1 cleanly.
  logic [DATA_W-1:0] view  [NREG];

  logic [ADDR_W-1:0] ra [NPORT];
  logic [DATA_W-1:0] rd [NPORT];

  logic wr_hit;

  // Write qualifies only on an explicit WE=1 to a non-zero address; WE=X cannot reach x0.
  assign wr_hit = (WE == 1'b1) && (WA != '0);

  // Storage: async clear of every register, synchronous write on rising CLK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 1; i < NREG; i++) begin
        store[i] <= '0;
      end
    end else if (wr_hit) begin
      store[WA] <= WD;
    end
  end

  // Build the zero-extended read view; the async clear makes reads 0 during reset.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      view[i] = store[i];
    end
  end

  assign ra[0] = RA1;
  assign ra[1] = RA2;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    // Per-port read mux, with optional write-through forwarding on address match.
    always_comb begin
      rd[p] = '0;
      if (ra[p] != '0) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (ra[p] == WA)) begin
          rd[p] = WD;
        end else begin
          rd[p] = view[ra[p]];
        end
`else
        rd[p] = view[ra[p]];
`endif
      end
    end
  end

  assign RD1 = rd[0];
  assign RD2 = rd[1];

endmodule
